eta_accum: RTL and testbench
============================

# eta_accum

Streaming approximate accumulator for the DNN datapath, built around an error-tolerant adder (ETA-I) whose approximate/accurate border is selected at run time rather than fixed at elaboration. It consumes a window of unsigned operands over a valid/ready stream, accumulates them into a saturating register, and emits one sum per window. It sits between the multiplier array and the activation stage and lets a layer trade accuracy for energy per window. Optional error monitoring runs an exact shadow accumulator for characterisation builds.

## Interface
- BITWIDTH, 8, operand width (unsigned)
- ACCWIDTH, 16, accumulator and result width; must be ≥ BITWIDTH+1
- MAX_BORDER, 4, largest supported approximate-region width; must be < BITWIDTH
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- border_i  in  $clog2(MAX_BORDER+1)  approximate-region width requested for the window; sampled on the window's first beat
- in_valid  in  1  operand beat valid
- in_ready  out  1  block accepts a beat this cycle
- in_data  in  BITWIDTH  operand, zero-extended to ACCWIDTH
- in_last  in  1  final beat of the window
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts the result
- out_sum  out  ACCWIDTH  window sum
- out_ovf  out  1  saturation occurred in this window
- err_o  out  ACCWIDTH+1  signed, exact minus approximate sum (ETA_ACCUM_ERRMON_EN only)

## Operation
- Beat accepted when in_valid && in_ready.
- FSM states: IDLE, ACCUM, HOLD.
  - IDLE: in_ready=1. On a beat, latch border = min(border_i, MAX_BORDER), acc = in_data, clear overflow. Go to HOLD if in_last, else ACCUM.
  - ACCUM: in_ready=1. On a beat, acc = eta_add(acc, in_data, border). Go to HOLD on in_last.
  - HOLD: in_ready=0, out_valid=1, out_sum and out_ovf stable. On out_ready, go to IDLE.
- eta_add, bits [border-1:0] (approximate region):
  - Scan from bit border-1 down to bit 0.
  - Each bit is a|b until the first position where a&b=1.
  - That bit and every lower bit are forced to 1.
- eta_add, bits [ACCWIDTH-1:border] (accurate region): exact add with carry-in 0.
  - border=0 gives a fully exact add.
- Saturation: carry out of bit ACCWIDTH-1 in the accurate region sets acc to all ones and sets out_ovf (sticky for the window). Later beats add into the saturated value normally; it re-saturates.
- border_i changes mid-window are ignored.
- Reset:
  - Values after reset: state=IDLE, acc=0, out_valid=0, out_sum=0, out_ovf=0, err_o=0; in_ready=1 in the cycle after reset deasserts.
  - Reset mid-window discards the partial sum. No output is produced for that window.

## Timing
- The accumulate step is single-cycle combinational into acc. Throughput is one beat per clock while in ACCUM.
- out_valid rises the cycle after the beat carrying in_last is accepted.
- Handshake cycles:
  - The out_valid && out_ready cycle leaves HOLD; in_ready=1 the following cycle.
  - Minimum one bubble between windows. No same-cycle input/output overlap.
- out_sum and out_ovf hold their values while out_valid=0 after a transfer; consumers must qualify with out_valid.
- A beat offered during HOLD is not accepted and must be held by the source.

## Configuration
- ETA_ACCUM_ERRMON_EN defined:
  - Adds an exact shadow accumulator of ACCWIDTH bits, saturating with the same rule.
  - err_o = shadow − acc, sign-extended, valid with out_valid.
- Not defined: no shadow logic; err_o is tied to 0.

## Structure
- Package eta_pkg contains:
  - state enum (IDLE, ACCUM, HOLD)
  - border width constant function $clog2(MAX_BORDER+1)
  - the saturation helper
- Sub-module eta_add holds the combinational runtime-border ETA-I adder. Ports: a, b [ACCWIDTH], border, sum [ACCWIDTH], cout. It is reused by the shadow path with border tied to 0.

## Test plan
- border_i=0, beats 100, 200, 50(last) -> out_sum=350, out_ovf=0, err_o=0.
- border_i=2, beats 3, 3(last) -> out_sum=3 (exact 6); with ERRMON, err_o=+3.
- border_i=0, 258 beats of 255 -> out_sum=65535, out_ovf=1. Repeat with 257 beats -> out_sum=65535, out_ovf=0.
- Single-beat window: 77 with in_last -> out_sum=77; out_valid the next cycle.
- Backpressure: out_ready=0 for 5 cycles -> out_sum stable, in_ready=0, offered beat not consumed; out_ready=1 -> in_ready=1 the next cycle.
- border_i=7 (clamped to 4) and border_i changed mid-window -> window uses 4 throughout. rst asserted mid-window -> out_valid stays 0; the next window's sum excludes prior beats.

Source files
------------

// File: rtl/eta_pkg.sv
// Shared types and helpers for the runtime-border ETA-I accumulator:
// FSM state encoding, border-select width and the saturation rule.
package eta_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  function automatic int border_width(input int max_border);
    return $clog2(max_border + 1);
  endfunction

  // Carry out of the accurate region pins the result to all ones of 'width' bits.
  function automatic logic [63:0] saturate(input logic [63:0] sum, input logic cout,
                                           input int width);
    return cout ? ((64'd1 << width) - 64'd1) : sum;
  endfunction

endpackage

// File: rtl/eta_add.sv
// Combinational ETA-I adder with a run-time border: OR-with-forced-ones below
// the border, exact add (carry-in 0) at and above it. border=0 is a plain add.
module eta_add
  import eta_pkg::*;
#(
  parameter int ACCWIDTH   = 16,
  parameter int MAX_BORDER = 4,
  localparam int BW        = border_width(MAX_BORDER)
) (
  input  logic [ACCWIDTH-1:0] a,
  input  logic [ACCWIDTH-1:0] b,
  input  logic [BW-1:0]       border,
  output logic [ACCWIDTH-1:0] sum,
  output logic                cout
);

  localparam logic [ACCWIDTH-1:0] ONE = ACCWIDTH'(1);

  logic [ACCWIDTH-1:0]   low_mask;
  logic [ACCWIDTH:0]     hi_sum;
  logic [MAX_BORDER-1:0] gen;
  logic [MAX_BORDER-1:0] forced;
  logic [MAX_BORDER-1:0] low_bits;

  assign low_mask = (ONE << border) - ONE;
  assign gen      = a[MAX_BORDER-1:0] & b[MAX_BORDER-1:0] & low_mask[MAX_BORDER-1:0];

  // Masked operands have zero low bits, so no carry ever crosses the border.
  assign hi_sum = {1'b0, a & ~low_mask} + {1'b0, b & ~low_mask};

  // A bit is forced high if it or any higher approximate bit generates.
  generate
    for (genvar gi = 0; gi < MAX_BORDER; gi++) begin : g_approx
      assign forced[gi]   = |gen[MAX_BORDER-1:gi];
      assign low_bits[gi] = forced[gi] | a[gi] | b[gi];
    end
  endgenerate

  assign sum  = (hi_sum[ACCWIDTH-1:0] & ~low_mask)
              | ({{(ACCWIDTH-MAX_BORDER){1'b0}}, low_bits} & low_mask);
  assign cout = hi_sum[ACCWIDTH];

endmodule

// File: rtl/eta_accum.sv
// Windowed saturating accumulator built on the runtime-border ETA-I adder.
// Define ETA_ACCUM_ERRMON_EN to add an exact shadow accumulator driving err_o.
module eta_accum
  import eta_pkg::*;
#(
  parameter int BITWIDTH   = 8,
  parameter int ACCWIDTH   = 16,
  parameter int MAX_BORDER = 4,
  localparam int BW        = border_width(MAX_BORDER)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [BW-1:0]       border_i,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [BITWIDTH-1:0] in_data,
  input  logic                in_last,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [ACCWIDTH-1:0] out_sum,
  output logic                out_ovf,
  output logic [ACCWIDTH:0]   err_o
);

  localparam logic [BW-1:0] MAX_B = BW'(MAX_BORDER);

  state_t              state_q, state_d;
  logic [ACCWIDTH-1:0] acc_q, acc_d;
  logic                ovf_q, ovf_d;
  logic [BW-1:0]       border_q, border_d;

  logic [ACCWIDTH-1:0] data_ext;
  logic [ACCWIDTH-1:0] add_sum;
  logic                add_cout;
  logic                beat;

  assign data_ext = {{(ACCWIDTH-BITWIDTH){1'b0}}, in_data};
  assign in_ready = (state_q != HOLD);
  assign beat     = in_valid && in_ready;

  eta_add #(
    .ACCWIDTH  (ACCWIDTH),
    .MAX_BORDER(MAX_BORDER)
  ) u_add (
    .a     (acc_q),
    .b     (data_ext),
    .border(border_q),
    .sum   (add_sum),
    .cout  (add_cout)
  );

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    ovf_d    = ovf_q;
    border_d = border_q;
    case (state_q)
      IDLE: begin
        if (beat) begin
          border_d = (border_i > MAX_B) ? MAX_B : border_i;
          acc_d    = data_ext;
          ovf_d    = 1'b0;
          state_d  = in_last ? HOLD : ACCUM;
        end
      end
      ACCUM: begin
        if (beat) begin
          acc_d = ACCWIDTH'(saturate(64'(add_sum), add_cout, ACCWIDTH));
          ovf_d = ovf_q | add_cout;
          if (in_last) state_d = HOLD;
        end
      end
      HOLD: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      ovf_q    <= 1'b0;
      border_q <= '0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      ovf_q    <= ovf_d;
      border_q <= border_d;
    end
  end

  assign out_valid = (state_q == HOLD);
  assign out_sum   = acc_q;
  assign out_ovf   = ovf_q;

`ifdef ETA_ACCUM_ERRMON_EN
  logic [ACCWIDTH-1:0] shadow_q, shadow_d;
  logic [ACCWIDTH-1:0] shadow_sum;
  logic                shadow_cout;

  eta_add #(
    .ACCWIDTH  (ACCWIDTH),
    .MAX_BORDER(MAX_BORDER)
  ) u_shadow (
    .a     (shadow_q),
    .b     (data_ext),
    .border('0),
    .sum   (shadow_sum),
    .cout  (shadow_cout)
  );

  always_comb begin
    shadow_d = shadow_q;
    if (beat) begin
      if (state_q == IDLE) shadow_d = data_ext;
      else                 shadow_d = ACCWIDTH'(saturate(64'(shadow_sum), shadow_cout, ACCWIDTH));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) shadow_q <= '0;
    else     shadow_q <= shadow_d;
  end

  assign err_o = {1'b0, shadow_q} - {1'b0, acc_q};
`else
  assign err_o = '0;
`endif

endmodule

// File: tb/tb_eta_accum.sv
// Scoreboard bench for eta_accum: a bit-serial ETA-I model predicts each window
// result at drive time; each test pops and compares when out_valid appears.
module tb_eta_accum;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  border_i;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_sum;
  logic        out_ovf;
  logic [16:0] err_o;

  typedef struct {
    logic [15:0] sum;
    logic        ovf;
    logic [16:0] err;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] win_q[$];
  int         n_checks = 0;
  int         n_fail   = 0;

  always #5 clk = ~clk;

  eta_accum dut (
    .clk      (clk),
    .rst      (rst),
    .border_i (border_i),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_last  (in_last),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_sum  (out_sum),
    .out_ovf  (out_ovf),
    .err_o    (err_o)
  );

  // Returns {cout, sum}; approximate bits are scanned MSB-first as ETA-I describes.
  function automatic logic [16:0] eta_model(logic [15:0] a, logic [15:0] b, int border);
    logic [15:0] low;
    logic [31:0] hi;
    logic        forced;
    low    = '0;
    forced = 1'b0;
    for (int i = border - 1; i >= 0; i--) begin
      if (a[i] && b[i]) forced = 1'b1;
      low[i] = forced | a[i] | b[i];
    end
    hi = ((32'(a) >> border) + (32'(b) >> border)) << border;
    return {hi[16], hi[15:0] | low};
  endfunction

  task automatic predict(input int border_first);
    int          bd;
    logic [15:0] acc, sh;
    logic [16:0] r;
    exp_t        e;
    bd    = (border_first > 4) ? 4 : border_first;
    acc   = 16'(win_q[0]);
    sh    = 16'(win_q[0]);
    e.ovf = 1'b0;
    for (int i = 1; i < win_q.size(); i++) begin
      r     = eta_model(acc, 16'(win_q[i]), bd);
      acc   = r[16] ? 16'hFFFF : r[15:0];
      e.ovf = e.ovf | r[16];
      r     = eta_model(sh, 16'(win_q[i]), 0);
      sh    = r[16] ? 16'hFFFF : r[15:0];
    end
    e.sum = acc;
`ifdef ETA_ACCUM_ERRMON_EN
    e.err = {1'b0, sh} - {1'b0, acc};
`else
    e.err = '0;
`endif
    sb.push_back(e);
  endtask

  // Called just after a posedge; returns just after the edge accepting the last beat.
  task automatic drive_window(input int border_first, input int border_rest);
    logic rdy;
    int   cnt;
    for (int i = 0; i < win_q.size(); i++) begin
      in_valid = 1'b1;
      in_data  = win_q[i];
      in_last  = (i == win_q.size() - 1);
      border_i = 3'((i == 0) ? border_first : border_rest);
      cnt = 0;
      forever begin
        @(negedge clk);
        rdy = in_ready;
        @(posedge clk);
        #1;
        if (rdy) break;
        cnt++;
        if (cnt > 50) begin
          $display("FAIL drive_timeout: in_ready stayed 0 (got 0, expected 1)");
          $fatal(1, "stalled");
        end
      end
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_out();
    int cnt = 0;
    @(negedge clk);
    while (out_valid !== 1'b1) begin
      cnt++;
      if (cnt > 50) begin
        $display("FAIL out_timeout: out_valid got %b expected 1", out_valid);
        $fatal(1, "no output");
      end
      @(negedge clk);
    end
  endtask

  task automatic take_out();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    border_i  = '0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    n_checks += 5;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b expected 0", out_valid); end
    if (out_sum !== 16'd0)  begin n_fail++; $display("FAIL reset_out_sum got %0d expected 0", out_sum); end
    if (out_ovf !== 1'b0)   begin n_fail++; $display("FAIL reset_out_ovf got %b expected 0", out_ovf); end
    if (err_o !== 17'd0)    begin n_fail++; $display("FAIL reset_err got %0d expected 0", err_o); end
    if (in_ready !== 1'b1)  begin n_fail++; $display("FAIL reset_in_ready got %b expected 1", in_ready); end
    $display("reset: out_valid=%b out_sum=%0d in_ready=%b", out_valid, out_sum, in_ready);
    @(posedge clk);
    #1;
  endtask

  // Exact, approximate and saturation windows from a small table.
  task automatic test_windows();
    int   borders[4] = '{0, 2, 0, 0};
    int   lens[4]    = '{3, 2, 258, 257};
    exp_t e;
    for (int w = 0; w < 4; w++) begin
      win_q.delete();
      if (w == 0) begin win_q.push_back(8'd100); win_q.push_back(8'd200); win_q.push_back(8'd50); end
      else if (w == 1) begin win_q.push_back(8'd3); win_q.push_back(8'd3); end
      else for (int i = 0; i < lens[w]; i++) win_q.push_back(8'd255);
      predict(borders[w]);
      drive_window(borders[w], borders[w]);
      wait_out();
      e = sb.pop_front();
      n_checks += 3;
      if (out_sum !== e.sum) begin n_fail++; $display("FAIL window%0d_sum got %0d expected %0d", w, out_sum, e.sum); end
      if (out_ovf !== e.ovf) begin n_fail++; $display("FAIL window%0d_ovf got %b expected %b", w, out_ovf, e.ovf); end
      if (err_o !== e.err)   begin n_fail++; $display("FAIL window%0d_err got %0d expected %0d", w, $signed(err_o), $signed(e.err)); end
      $display("window%0d: border=%0d beats=%0d sum=%0d ovf=%b err=%0d", w, borders[w], lens[w], out_sum, out_ovf, $signed(err_o));
      take_out();
    end
  endtask

  task automatic test_single_beat();
    exp_t e;
    win_q.delete();
    win_q.push_back(8'd77);
    predict(0);
    drive_window(0, 0);
    e = sb.pop_front();
    n_checks += 3;
    if (out_valid !== 1'b1) begin n_fail++; $display("FAIL single_latency out_valid got %b expected 1", out_valid); end
    if (out_sum !== e.sum)  begin n_fail++; $display("FAIL single_sum got %0d expected %0d", out_sum, e.sum); end
    if (out_ovf !== e.ovf)  begin n_fail++; $display("FAIL single_ovf got %b expected %b", out_ovf, e.ovf); end
    $display("single: sum=%0d out_valid=%b", out_sum, out_valid);
    take_out();
  endtask

  task automatic test_backpressure();
    exp_t e;
    win_q.delete();
    win_q.push_back(8'd40);
    win_q.push_back(8'd2);
    predict(0);
    drive_window(0, 0);
    wait_out();
    e = sb.pop_front();
    win_q.delete();
    win_q.push_back(8'd9);
    predict(0);
    in_valid = 1'b1;
    in_data  = 8'd9;
    in_last  = 1'b1;
    border_i = '0;
    for (int c = 0; c < 5; c++) begin
      n_checks += 3;
      if (out_sum !== e.sum)   begin n_fail++; $display("FAIL bp_sum_c%0d got %0d expected %0d", c, out_sum, e.sum); end
      if (in_ready !== 1'b0)   begin n_fail++; $display("FAIL bp_in_ready_c%0d got %b expected 0", c, in_ready); end
      if (out_valid !== 1'b1)  begin n_fail++; $display("FAIL bp_out_valid_c%0d got %b expected 1", c, out_valid); end
      $display("backpressure c%0d: sum=%0d in_ready=%b", c, out_sum, in_ready);
      @(negedge clk);
    end
    take_out();
    n_checks++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release_in_ready got %b expected 1", in_ready); end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    wait_out();
    e = sb.pop_front();
    n_checks += 2;
    if (out_sum !== e.sum) begin n_fail++; $display("FAIL bp_held_beat_sum got %0d expected %0d", out_sum, e.sum); end
    if (out_ovf !== e.ovf) begin n_fail++; $display("FAIL bp_held_beat_ovf got %b expected %b", out_ovf, e.ovf); end
    $display("backpressure: held beat window sum=%0d", out_sum);
    take_out();
  endtask

  task automatic test_clamp();
    exp_t e;
    win_q.delete();
    win_q.push_back(8'h31);
    win_q.push_back(8'h31);
    predict(7);
    drive_window(7, 0);
    wait_out();
    e = sb.pop_front();
    n_checks += 2;
    if (out_sum !== e.sum) begin n_fail++; $display("FAIL clamp_sum got %0d expected %0d", out_sum, e.sum); end
    if (err_o !== e.err)   begin n_fail++; $display("FAIL clamp_err got %0d expected %0d", $signed(err_o), $signed(e.err)); end
    $display("clamp: border_i=7 then 0, sum=0x%h", out_sum);
    take_out();
  endtask

  task automatic test_reset_mid_window();
    exp_t e;
    in_valid = 1'b1;
    in_last  = 1'b0;
    border_i = '0;
    in_data  = 8'd10;
    @(posedge clk); #1;
    in_data  = 8'd20;
    @(posedge clk); #1;
    in_valid = 1'b0;
    rst      = 1'b1;
    @(posedge clk); #1;
    rst      = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_checks += 2;
      if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_out_valid_c%0d got %b expected 0", c, out_valid); end
      if (in_ready !== 1'b1)  begin n_fail++; $display("FAIL rstmid_in_ready_c%0d got %b expected 1", c, in_ready); end
    end
    @(posedge clk); #1;
    win_q.delete();
    win_q.push_back(8'd5);
    win_q.push_back(8'd6);
    predict(0);
    drive_window(0, 0);
    wait_out();
    e = sb.pop_front();
    n_checks++;
    if (out_sum !== e.sum) begin n_fail++; $display("FAIL rstmid_next_sum got %0d expected %0d", out_sum, e.sum); end
    $display("reset mid-window: next window sum=%0d", out_sum);
    take_out();
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int   bd;
    for (int w = 0; w < 8; w++) begin
      win_q.delete();
      for (int i = 0; i < int'($urandom_range(1, 6)); i++) win_q.push_back(8'($urandom_range(0, 255)));
      bd = $urandom_range(0, 7);
      predict(bd);
      drive_window(bd, $urandom_range(0, 7));
      wait_out();
      e = sb.pop_front();
      n_checks += 3;
      if (out_sum !== e.sum) begin n_fail++; $display("FAIL b2b%0d_sum got %0d expected %0d", w, out_sum, e.sum); end
      if (out_ovf !== e.ovf) begin n_fail++; $display("FAIL b2b%0d_ovf got %b expected %b", w, out_ovf, e.ovf); end
      if (err_o !== e.err)   begin n_fail++; $display("FAIL b2b%0d_err got %0d expected %0d", w, $signed(err_o), $signed(e.err)); end
      $display("b2b%0d: border=%0d beats=%0d sum=%0d err=%0d", w, bd, win_q.size(), out_sum, $signed(err_o));
      take_out();
    end
  endtask

  initial begin
    test_reset();
    test_windows();
    test_single_beat();
    test_backpressure();
    test_clamp();
    test_reset_mid_window();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
